// File: rtl/uart_rx_xor.sv
// Oversampling UART receiver with XOR payload decryption (rx side of the uart_top link).
// Optional parity check is enabled with `define UART_RX_PARITY_EN.
module uart_rx_xor #(
  parameter int              DBIT   = 8,
  parameter int              S_TICK = 16,
  parameter logic [DBIT-1:0] KEY    = '0
`ifdef UART_RX_PARITY_EN
  , parameter bit            PARITY_ODD = 1'b0
`endif
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx_serial,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_done,
  output logic            rx_frame_error
`ifdef UART_RX_PARITY_EN
  , output logic          rx_parity_error
`endif
);
  localparam int SW = $clog2(S_TICK);
  localparam int NW = $clog2(DBIT + 1);
  localparam logic [SW-1:0] S_LAST = SW'(S_TICK - 1);
  localparam logic [SW-1:0] S_MID  = SW'(S_TICK / 2 - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state, state_n;
  logic [SW-1:0]   s, s_n;
  logic [NW-1:0]   n, n_n;
  logic [DBIT-1:0] shift, shift_n, data_n;
  logic            sync1, rx_s;
  logic            done_n, ferr_n, stop_hit;
`ifdef UART_RX_PARITY_EN
  logic            par, par_n, perr_n;
`endif

  // state + datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      s              <= '0;
      n              <= '0;
      shift          <= '0;
      sync1          <= 1'b1;
      rx_s           <= 1'b1;
      rx_data        <= '0;
      rx_done        <= 1'b0;
      rx_frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par             <= 1'b0;
      rx_parity_error <= 1'b0;
`endif
    end else begin
      state          <= state_n;
      s              <= s_n;
      n              <= n_n;
      shift          <= shift_n;
      sync1          <= rx_serial;
      rx_s           <= sync1;
      rx_data        <= data_n;
      rx_done        <= done_n;
      rx_frame_error <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par             <= par_n;
      rx_parity_error <= perr_n;
`endif
    end
  end

  // next state
  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    shift_n = shift;
`ifdef UART_RX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: if (!rx_s) begin
        state_n = START;
        s_n     = '0;
      end
      START: if (s_tick) begin
        if (s == S_MID) begin
          s_n     = '0;
          n_n     = '0;
          state_n = rx_s ? IDLE : DATA;  // high at mid start bit: glitch, not a frame
        end else s_n = s + 1'b1;
      end
      DATA: if (s_tick) begin
        if (s == S_LAST) begin
          s_n     = '0;
          shift_n = {rx_s, shift[DBIT-1:1]};
          n_n     = n + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (n == N_LAST) state_n = PARITY;
`else
          if (n == N_LAST) state_n = STOP;
`endif
        end else s_n = s + 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (s_tick) begin
        if (s == S_LAST) begin
          s_n     = '0;
          par_n   = rx_s;
          state_n = STOP;
        end else s_n = s + 1'b1;
      end
`endif
      STOP: if (s_tick) begin
        if (s == S_LAST) begin
          s_n     = '0;
          state_n = IDLE;  // leave at mid stop bit so back-to-back frames are caught
        end else s_n = s + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // outputs: update only on the stop-bit sample, otherwise hold
  always_comb begin
    stop_hit = (state == STOP) && s_tick && (s == S_LAST);
    done_n   = stop_hit;
    data_n   = stop_hit ? (shift ^ KEY) : rx_data;
    ferr_n   = stop_hit ? ~rx_s : rx_frame_error;
`ifdef UART_RX_PARITY_EN
    perr_n   = stop_hit ? (^shift ^ par ^ PARITY_ODD) : rx_parity_error;
`endif
  end
endmodule

// File: tb/tb_uart_rx_xor.sv
// Directed bench for uart_rx_xor: one KEY=0 and one KEY=8'h5A receiver on a shared line.
module tb_uart_rx_xor;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tick = 1'b1;
  logic       rx_serial = 1'b1;
  logic [7:0] rx_data0, rx_data1;
  logic       rx_done0, rx_done1, ferr0, ferr1;
`ifdef UART_RX_PARITY_EN
  logic       perr0, perr1;
`endif

  int n_cmp = 0, n_err = 0;
  int cnt0 = 0, cnt1 = 0, run0 = 0, run1 = 0, max0 = 0, max1 = 0;
  int c0, c1;

  always #5 clk = ~clk;

  uart_rx_xor #(.DBIT(8), .S_TICK(16), .KEY(8'h00)) dut0 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx_serial(rx_serial),
    .rx_data(rx_data0), .rx_done(rx_done0), .rx_frame_error(ferr0)
`ifdef UART_RX_PARITY_EN
    , .rx_parity_error(perr0)
`endif
  );

  uart_rx_xor #(.DBIT(8), .S_TICK(16), .KEY(8'h5A)) dut1 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx_serial(rx_serial),
    .rx_data(rx_data1), .rx_done(rx_done1), .rx_frame_error(ferr1)
`ifdef UART_RX_PARITY_EN
    , .rx_parity_error(perr1)
`endif
  );

  // pulse counter and pulse-width tracker, sampled mid-cycle
  always @(negedge clk) begin
    if (rx_done0) begin cnt0++; run0++; if (run0 > max0) max0 = run0; end else run0 = 0;
    if (rx_done1) begin cnt1++; run1++; if (run1 > max1) max1 = run1; end else run1 = 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic b, input int clks);
    rx_serial = b;
    repeat (clks) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] d, input logic par, input logic stop);
    hold(1'b0, 16);
    for (int i = 0; i < 8; i++) hold(d[i], 16);
`ifdef UART_RX_PARITY_EN
    hold(par, 16);
`endif
    hold(stop, 16);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_data", {24'd0, rx_data0}, 32'h00);
    chk("reset_done", {31'd0, rx_done0}, 32'h0);
    chk("reset_ferr", {31'd0, ferr0}, 32'h0);
    reset_n = 1'b1;
    hold(1'b1, 20);

    // 1: plain frame
    c0 = cnt0; c1 = cnt1;
    frame(8'hA5, 1'b0, 1'b1);
    chk("t1_cnt", cnt0 - c0, 32'd1);
    chk("t1_data", {24'd0, rx_data0}, 32'hA5);
    chk("t1_ferr", {31'd0, ferr0}, 32'h0);
    chk("t1_data_key", {24'd0, rx_data1}, 32'hFF);

    // 2: decryption, then back-to-back frame
    hold(1'b1, 10);
    c1 = cnt1;
    frame(8'hFF, 1'b0, 1'b1);
    chk("t2a_data", {24'd0, rx_data1}, 32'hA5);
    chk("t2a_ferr", {31'd0, ferr1}, 32'h0);
    frame(8'h66, 1'b0, 1'b1);
    chk("t2b_cnt", cnt1 - c1, 32'd2);
    chk("t2b_data", {24'd0, rx_data1}, 32'h3C);

    // 3: short glitch rejected
    hold(1'b1, 10);
    c0 = cnt0;
    hold(1'b0, 4);
    hold(1'b1, 40);
    chk("t3_glitch_cnt", cnt0 - c0, 32'd0);
    chk("t3_glitch_data", {24'd0, rx_data0}, 32'h66);
    frame(8'h81, 1'b0, 1'b1);
    chk("t3_cnt", cnt0 - c0, 32'd1);
    chk("t3_data", {24'd0, rx_data0}, 32'h81);

    // 4: framing error still delivers data
    hold(1'b1, 10);
    c0 = cnt0;
    frame(8'h3C, 1'b0, 1'b0);
    chk("t4_cnt", cnt0 - c0, 32'd1);
    chk("t4_data", {24'd0, rx_data0}, 32'h3C);
    chk("t4_ferr", {31'd0, ferr0}, 32'h1);
    hold(1'b1, 20);
    frame(8'h81, 1'b0, 1'b1);
    chk("t4b_data", {24'd0, rx_data0}, 32'h81);
    chk("t4b_ferr", {31'd0, ferr0}, 32'h0);

    // 5: reset during data bit 3 of 0xF0 abandons the frame
    hold(1'b1, 10);
    c0 = cnt0;
    hold(1'b0, 16);
    for (int i = 0; i < 3; i++) hold(1'b0, 16);
    hold(1'b0, 8);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rx_serial = 1'b1;
    chk("t5_rst_data", {24'd0, rx_data0}, 32'h00);
    chk("t5_rst_done", {31'd0, rx_done0}, 32'h0);
    chk("t5_rst_ferr", {31'd0, ferr0}, 32'h0);
    hold(1'b1, 200);
    chk("t5_no_done", cnt0 - c0, 32'd0);
    frame(8'h55, 1'b0, 1'b1);
    chk("t5_cnt", cnt0 - c0, 32'd1);
    chk("t5_data", {24'd0, rx_data0}, 32'h55);

`ifdef UART_RX_PARITY_EN
    // 6: even parity check on raw wire bits
    hold(1'b1, 10);
    frame(8'hA5, 1'b0, 1'b1);
    chk("t6_perr_ok", {31'd0, perr0}, 32'h0);
    chk("t6_data_ok", {24'd0, rx_data0}, 32'hA5);
    hold(1'b1, 10);
    frame(8'hA5, 1'b1, 1'b1);
    chk("t6_perr_bad", {31'd0, perr0}, 32'h1);
    chk("t6_data_bad", {24'd0, rx_data0}, 32'hA5);
    chk("t6_perr_key", {31'd0, perr1}, 32'h1);
`endif

    hold(1'b1, 5);
    chk("pulse_width0", max0, 32'd1);
    chk("pulse_width1", max1, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx_xor.md
Name: uart_rx_xor

Overview:
Oversampling UART receiver that recovers DBIT-bit frames from an asynchronous serial line and XOR-decrypts each payload with KEY. It is the receiving end of the encrypted link driven by the uart_top transmit path. It shares the s_tick baud-tick source and the rx_data/rx_done/rx_frame_error contract with uart_top, so it can replace or stand alongside the loopback receiver.

Parameters:
DBIT, 8, data bits per frame, sent LSB first
S_TICK, 16, s_tick pulses per bit period (even, >= 4)
KEY, 8'h00, XOR key of width DBIT, applied to each received word before output

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous, active-low reset
s_tick  input  1  oversampling enable, S_TICK pulses per bit period
rx_serial  input  1  asynchronous serial line, idle high
rx_data  output  DBIT  decrypted received word
rx_done  output  1  one-clk pulse, frame complete
rx_frame_error  output  1  stop bit sampled low on last frame

Behaviour:
- Reset is synchronous and active-low. While reset_n=0 at a clk edge:
  - rx_data=0, rx_done=0, rx_frame_error=0.
  - FSM goes to IDLE; tick counter and bit counter go to 0; shift register goes to 0; both synchronizer flops go to 1.
  - Reset asserted mid-frame abandons that frame; no rx_done is produced for it.
- Input path: rx_serial passes through a 2-flop synchronizer (rx_s). All decisions use rx_s.
- The tick counter s advances only on clocks with s_tick=1.
- IDLE: when rx_s=0, go to START with s=0.
- START: on s_tick with s=S_TICK/2-1:
  - rx_s=0: go to DATA with s=0 and n=0.
  - rx_s=1: false start; return to IDLE with no outputs changed.
- DATA: on s_tick with s=S_TICK-1:
  - Shift rx_s into the MSB of the shift register, shifting right, so bits arrive LSB first.
  - Set s=0 and n=n+1.
  - After DBIT samples, go to STOP (or PARITY, see Optional Feature).
- STOP: on s_tick with s=S_TICK-1:
  - Register rx_data = shift ^ KEY, rx_frame_error = ~rx_s, rx_done=1.
  - Go to IDLE. Returning at mid stop bit permits back-to-back frames.
- Output timing: rx_done is high for exactly one clk. rx_data and rx_frame_error change only with rx_done and hold until the next rx_done.
- Framing error: the data is still delivered and rx_done still pulses.
- Line held low (break): after the stop error, IDLE sees rx_s=0 and starts a new frame. No lock-up.
- s_tick=0: the FSM freezes in its current state. s_tick tied to 1 gives S_TICK clocks per bit.
- Latency: rx_done rises one clk after the STOP sample edge. The sample itself is taken 2 clks after the line change because of the synchronizer.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Adds parameter PARITY_ODD (default 0).
  - Adds output rx_parity_error (1 bit, reset 0).
  - Adds state PARITY between DATA and STOP. On s_tick with s=S_TICK-1 it samples the parity bit and then goes to STOP.
  - Parity is computed over the raw wire bits, before decryption. Even parity is used when PARITY_ODD=0.
  - rx_parity_error updates together with rx_done and holds until the next rx_done.
- When not defined: no PARITY state, no PARITY_ODD parameter and no rx_parity_error port. Frame is start + DBIT + stop.

Test Plan:
1. KEY=0, s_tick=1, send 0xA5 as a good frame (16 clks/bit) -> single rx_done pulse, rx_data=0xA5, rx_frame_error=0.
2. KEY=8'h5A, wire byte 0xFF -> rx_data=0xA5, rx_frame_error=0. Then wire byte 0x66 sent back-to-back with a 1-bit stop -> second rx_done, rx_data=0x3C.
3. 4-clk low glitch on the idle line -> no rx_done, FSM back in IDLE. A following good frame 0x81 is received correctly.
4. Frame 0x3C with stop bit driven 0 -> rx_done=1, rx_data=0x3C, rx_frame_error=1. Next good frame 0x81 -> rx_frame_error=0.
5. reset_n=0 for 1 clk during data bit 3 of 0xF0 -> all outputs 0 on the next clk, no rx_done for 0xF0. Next frame 0x55 gives rx_data=0x55.
6. UART_RX_PARITY_EN, PARITY_ODD=0: 0xA5 with parity bit 0 -> rx_parity_error=0. Same data with parity bit 1 -> rx_parity_error=1, rx_data=0xA5.
